// File: rtl/syscall_ctrl.sv
// SYSCALL service sequencer: latches $v0/$a0/pc on Sys, stalls decode while a service runs,
// streams bytes to the console, reads string bytes from data memory and owns the sticky halt.
module syscall_ctrl #(
    parameter logic [31:0] SYS_PRINT_INT = 32'd1,
    parameter logic [31:0] SYS_PRINT_STR = 32'd4,
    parameter logic [31:0] SYS_EXIT      = 32'd10,
    parameter logic [31:0] SYS_PRINT_CHR = 32'd11,
    parameter int unsigned MAX_STR_LEN   = 256
) (
    input  logic        clk,
    input  logic        rst_b,
    input  logic        Sys,
    input  logic [31:0] pc,
    input  logic [31:0] r_v0,
    input  logic [31:0] r_a0,
    output logic        sys_stall,
    output logic        syscall_halt,
    output logic        con_valid,
    output logic [7:0]  con_data,
    input  logic        con_ready,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic [7:0]  mem_rdata,
    input  logic        mem_rvalid
);

    localparam int unsigned LenW = $clog2(MAX_STR_LEN + 1);

    typedef enum logic [2:0] {
        StIdle, StHex, StChr, StStrReq, StStrWait, StStrEmit, StDone, StHalt
    } state_e;

    state_e            state_q, state_d;
    logic [31:0]       pc_q, pc_d;
    logic [31:0]       a0_q, a0_d;
    logic [2:0]        nib_q, nib_d;
    logic [31:0]       addr_q, addr_d;
    logic [LenW-1:0]   len_q, len_d;
    logic [7:0]        byte_q, byte_d;
    logic [3:0]        nib;
    logic              known_code;

    // pc is only kept for the end-of-program message in simulation environments.
    logic unused_pc;
    assign unused_pc = ^pc_q;

    assign known_code = (r_v0 == SYS_PRINT_INT) || (r_v0 == SYS_PRINT_STR) ||
                        (r_v0 == SYS_EXIT) || (r_v0 == SYS_PRINT_CHR);
    assign nib = a0_q[{nib_q, 2'b00} +: 4];

    always_ff @(posedge clk) begin
        if (rst_b) begin
            state_q <= StIdle;
            pc_q    <= '0;
            a0_q    <= '0;
            nib_q   <= '0;
            addr_q  <= '0;
            len_q   <= '0;
            byte_q  <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            a0_q    <= a0_d;
            nib_q   <= nib_d;
            addr_q  <= addr_d;
            len_q   <= len_d;
            byte_q  <= byte_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        a0_d         = a0_q;
        nib_d        = nib_q;
        addr_d       = addr_q;
        len_d        = len_q;
        byte_d       = byte_q;
        sys_stall    = 1'b0;
        syscall_halt = 1'b0;
        con_valid    = 1'b0;
        con_data     = 8'h00;
        mem_req      = 1'b0;
        mem_addr     = 32'h0;

        unique case (state_q)
            StIdle: begin
                // Unknown codes retire in zero cycles without stalling.
                if (Sys && known_code) begin
                    sys_stall = 1'b1;
                    pc_d      = pc;
                    a0_d      = r_a0;
                    if (r_v0 == SYS_EXIT) begin
                        state_d = StHalt;
                    end else if (r_v0 == SYS_PRINT_INT) begin
                        nib_d   = 3'd7;
                        state_d = StHex;
                    end else if (r_v0 == SYS_PRINT_CHR) begin
                        state_d = StChr;
                    end else begin
                        addr_d  = r_a0;
                        len_d   = '0;
                        state_d = StStrReq;
                    end
                end
            end
            StHex: begin
                sys_stall = 1'b1;
                con_valid = 1'b1;
                con_data  = (nib < 4'd10) ? {4'h3, nib} : (8'h37 + {4'h0, nib});
                if (con_ready) begin
                    if (nib_q == 3'd0) state_d = StDone;
                    else               nib_d   = nib_q - 3'd1;
                end
            end
            StChr: begin
                sys_stall = 1'b1;
                con_valid = 1'b1;
                con_data  = a0_q[7:0];
                if (con_ready) state_d = StDone;
            end
            StStrReq: begin
                sys_stall = 1'b1;
                mem_req   = 1'b1;
                mem_addr  = addr_q;
                state_d   = StStrWait;
            end
            StStrWait: begin
                sys_stall = 1'b1;
                if (mem_rvalid) begin
                    if (mem_rdata == 8'h00 || len_q == LenW'(MAX_STR_LEN)) begin
                        state_d = StDone;
                    end else begin
                        byte_d  = mem_rdata;
                        state_d = StStrEmit;
                    end
                end
            end
            StStrEmit: begin
                sys_stall = 1'b1;
                con_valid = 1'b1;
                con_data  = byte_q;
                if (con_ready) begin
                    addr_d  = addr_q + 32'd1;
                    len_d   = len_q + LenW'(1);
                    state_d = StStrReq;
                end
            end
            StDone: begin
                // Sys here is still the retiring SYSCALL, so it is ignored.
                state_d = StIdle;
            end
            StHalt: begin
                sys_stall    = 1'b1;
                syscall_halt = 1'b1;
            end
            default: state_d = StIdle;
        endcase
    end

endmodule

// File: tb/tb_syscall_ctrl.sv
// Directed bench for syscall_ctrl: console sink, latency-3 byte memory and stepwise checks.
module tb_syscall_ctrl;

    logic        clk = 1'b0;
    logic        rst_b = 1'b1;
    logic        Sys = 1'b0;
    logic [31:0] pc = '0;
    logic [31:0] r_v0 = '0;
    logic [31:0] r_a0 = '0;
    logic        sys_stall;
    logic        syscall_halt;
    logic        con_valid;
    logic [7:0]  con_data;
    logic        con_ready = 1'b0;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic [7:0]  mem_rdata = '0;
    logic        mem_rvalid = 1'b0;

    int errors = 0;
    int checks = 0;

    logic [7:0]  got[$];
    logic [31:0] reqs[$];
    int          mem_mode = 0;
    logic [31:0] mem_base = '0;

    syscall_ctrl dut (
        .clk          (clk),
        .rst_b        (rst_b),
        .Sys          (Sys),
        .pc           (pc),
        .r_v0         (r_v0),
        .r_a0         (r_a0),
        .sys_stall    (sys_stall),
        .syscall_halt (syscall_halt),
        .con_valid    (con_valid),
        .con_data     (con_data),
        .con_ready    (con_ready),
        .mem_req      (mem_req),
        .mem_addr     (mem_addr),
        .mem_rdata    (mem_rdata),
        .mem_rvalid   (mem_rvalid)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] mem_byte(input logic [31:0] a);
        logic [31:0] off;
        off = a - mem_base;
        if (mem_mode == 1) return 8'h41 + 8'(off % 32'd26);
        if (off == 32'd0) return 8'h48;
        if (off == 32'd1) return 8'h69;
        return 8'h00;
    endfunction

    // Console sink: records accepted bytes and checks held bytes stay put.
    logic       hold = 1'b0;
    logic [7:0] hold_data = '0;
    always @(posedge clk) begin
        if (rst_b) begin
            hold = 1'b0;
        end else begin
            if (hold) begin
                check("con_hold_valid", {31'd0, con_valid}, 32'd1);
                check("con_hold_data", {24'd0, con_data}, {24'd0, hold_data});
            end
            if (con_valid && con_ready) got.push_back(con_data);
            hold      = con_valid && !con_ready;
            hold_data = con_data;
        end
    end

    // Byte memory answering each request three cycles later.
    logic        mreq_s;
    logic [31:0] maddr_s;
    int          pend = 0;
    logic [31:0] pend_addr = '0;
    always @(posedge clk) begin
        mreq_s  = mem_req;
        maddr_s = mem_addr;
        #1;
        mem_rvalid = 1'b0;
        if (pend != 0) begin
            pend--;
            if (pend == 0) begin
                mem_rvalid = 1'b1;
                mem_rdata  = mem_byte(pend_addr);
            end
        end
        if (mreq_s === 1'b1) begin
            pend      = 2;
            pend_addr = maddr_s;
            reqs.push_back(maddr_s);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input string tag, input int bound, output int n);
        n = 0;
        while (sys_stall && n < bound) begin
            tick();
            n++;
        end
        check({tag, "_timeout"}, {31'd0, (n < bound)}, 32'd1);
    endtask

    task automatic check_str(input string tag, input string exp);
        check({tag, "_len"}, got.size(), exp.len());
        for (int i = 0; i < exp.len() && i < got.size(); i++)
            check({tag, "_byte"}, {24'd0, got[i]}, {24'd0, exp[i]});
    endtask

    task automatic issue(input logic [31:0] v0, input logic [31:0] a0);
        Sys  = 1'b1;
        r_v0 = v0;
        r_a0 = a0;
        #1;
        check("sys_cycle_stall", {31'd0, sys_stall}, 32'd1);
        tick();
        Sys = 1'b0;
        #1;
    endtask

    int n;

    initial begin
        tick();
        tick();
        check("rst_stall", {31'd0, sys_stall}, 32'd0);
        check("rst_halt", {31'd0, syscall_halt}, 32'd0);
        check("rst_con_valid", {31'd0, con_valid}, 32'd0);
        check("rst_con_data", {24'd0, con_data}, 32'd0);
        check("rst_mem_req", {31'd0, mem_req}, 32'd0);
        check("rst_mem_addr", mem_addr, 32'd0);
        rst_b = 1'b0;
        tick();

        // PRINT_CHR, Sys held through DONE as a stalled pipeline would.
        con_ready = 1'b1;
        pc   = 32'h0000_0400;
        Sys  = 1'b1;
        r_v0 = 32'd11;
        r_a0 = 32'h41;
        #1;
        check("chr_sys_stall", {31'd0, sys_stall}, 32'd1);
        tick();
        check("chr_stall", {31'd0, sys_stall}, 32'd1);
        check("chr_valid", {31'd0, con_valid}, 32'd1);
        check("chr_data", {24'd0, con_data}, 32'h41);
        tick();
        check("chr_done_stall", {31'd0, sys_stall}, 32'd0);
        check("chr_done_valid", {31'd0, con_valid}, 32'd0);
        Sys = 1'b0;
        tick();
        check("chr_idle_stall", {31'd0, sys_stall}, 32'd0);
        check_str("chr", "A");
        got.delete();

        // PRINT_INT with con_ready toggling every cycle.
        con_ready = 1'b0;
        issue(32'd1, 32'hDEAD_BEEF);
        n = 0;
        while (sys_stall && n < 60) begin
            con_ready = ~con_ready;
            tick();
            n++;
        end
        check("hex_toggle_timeout", {31'd0, (n < 60)}, 32'd1);
        check_str("hex_toggle", "DEADBEEF");
        got.delete();
        tick();

        // PRINT_INT with con_ready high: eight emitting cycles.
        con_ready = 1'b1;
        issue(32'd1, 32'h90AF_1234);
        wait_idle("hex_fast", 40, n);
        check("hex_fast_cycles", n, 32'd8);
        check_str("hex_fast", "90AF1234");
        got.delete();
        tick();

        // PRINT_STR "Hi" at 0x100.
        mem_mode = 0;
        mem_base = 32'h100;
        reqs.delete();
        issue(32'd4, 32'h100);
        wait_idle("str", 100, n);
        check_str("str", "Hi");
        check("str_nreq", reqs.size(), 32'd3);
        if (reqs.size() == 3) begin
            check("str_req0", reqs[0], 32'h100);
            check("str_req1", reqs[1], 32'h101);
            check("str_req2", reqs[2], 32'h102);
        end
        got.delete();
        tick();

        // PRINT_STR across the address wrap.
        mem_base = 32'hFFFF_FFFF;
        reqs.delete();
        issue(32'd4, 32'hFFFF_FFFF);
        wait_idle("wrap", 100, n);
        check_str("wrap", "Hi");
        check("wrap_nreq", reqs.size(), 32'd3);
        if (reqs.size() == 3) begin
            check("wrap_req0", reqs[0], 32'hFFFF_FFFF);
            check("wrap_req1", reqs[1], 32'h0);
            check("wrap_req2", reqs[2], 32'h1);
        end
        got.delete();
        tick();

        // Unterminated string is capped at 256 bytes.
        mem_mode = 1;
        mem_base = 32'h2000;
        reqs.delete();
        issue(32'd4, 32'h2000);
        wait_idle("cap", 3000, n);
        check("cap_len", got.size(), 32'd256);
        check("cap_nreq", reqs.size(), 32'd257);
        if (got.size() == 256) begin
            check("cap_first", {24'd0, got[0]}, 32'h41);
            check("cap_last", {24'd0, got[255]}, 32'h56);
        end
        got.delete();
        tick();

        // Unknown service code.
        Sys  = 1'b1;
        r_v0 = 32'd7;
        r_a0 = 32'h55;
        #1;
        check("unk_stall", {31'd0, sys_stall}, 32'd0);
        tick();
        Sys = 1'b0;
        check("unk_stall_after", {31'd0, sys_stall}, 32'd0);
        check("unk_con_valid", {31'd0, con_valid}, 32'd0);
        check("unk_mem_req", {31'd0, mem_req}, 32'd0);
        tick();

        // Reset while a hex byte is held.
        con_ready = 1'b0;
        issue(32'd1, 32'h1234_5678);
        tick();
        check("rmid_valid", {31'd0, con_valid}, 32'd1);
        check("rmid_data", {24'd0, con_data}, 32'h31);
        rst_b = 1'b1;
        tick();
        check("rmid_stall", {31'd0, sys_stall}, 32'd0);
        check("rmid_con_valid", {31'd0, con_valid}, 32'd0);
        check("rmid_con_data", {24'd0, con_data}, 32'd0);
        check("rmid_halt", {31'd0, syscall_halt}, 32'd0);
        rst_b = 1'b0;
        tick();
        check("rmid_nbytes", got.size(), 32'd0);
        got.delete();

        // EXIT: sticky halt that ignores further SYSCALLs.
        con_ready = 1'b1;
        pc = 32'h0000_0123;
        Sys  = 1'b1;
        r_v0 = 32'd10;
        #1;
        check("halt_pre", {31'd0, syscall_halt}, 32'd0);
        check("halt_sys_stall", {31'd0, sys_stall}, 32'd1);
        tick();
        check("halt_set", {31'd0, syscall_halt}, 32'd1);
        r_v0 = 32'd11;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("halt_hold", {31'd0, syscall_halt}, 32'd1);
            check("halt_stall", {31'd0, sys_stall}, 32'd1);
            check("halt_con_valid", {31'd0, con_valid}, 32'd0);
        end
        Sys = 1'b0;
        rst_b = 1'b1;
        tick();
        check("halt_reset", {31'd0, syscall_halt}, 32'd0);
        rst_b = 1'b0;
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
